// File: rtl/umi_splitter_n.sv
// umi_splitter_n: routes each UMI packet by a dstaddr bit field into one of N
// per-channel FIFOs, each draining independently through its own valid/ready port.
module umi_splitter_n #(
    parameter int DW     = 256,
    parameter int AW     = 64,
    parameter int CW     = 32,
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int SELLSB = 40
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic                              umi_in_valid,
    input  logic [CW-1:0]                     umi_in_cmd,
    input  logic [AW-1:0]                     umi_in_dstaddr,
    input  logic [AW-1:0]                     umi_in_srcaddr,
    input  logic [DW-1:0]                     umi_in_data,
    output logic                              umi_in_ready,
    output logic [N-1:0]                      umi_out_valid,
    output logic [N*CW-1:0]                   umi_out_cmd,
    output logic [N*AW-1:0]                   umi_out_dstaddr,
    output logic [N*AW-1:0]                   umi_out_srcaddr,
    output logic [N*DW-1:0]                   umi_out_data,
    input  logic [N-1:0]                      umi_out_ready,
    output logic [N*$clog2(DEPTH+1)-1:0]      fifo_count
);
    localparam int SW   = $clog2(N);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int EW   = CW + 2 * AW + DW;

    logic [SW-1:0] w_sel;
    logic [N-1:0]  w_full;
    logic [EW-1:0] w_entry;

    assign w_sel        = umi_in_dstaddr[SELLSB +: SW];
    assign w_entry      = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
    // Ready looks only at the registered count, so out_ready never reaches in_ready.
    assign umi_in_ready = !w_full[w_sel];

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [EW-1:0]   r_mem [DEPTH];
        logic [PW-1:0]   r_wptr;
        logic [PW-1:0]   r_rptr;
        logic [CNTW-1:0] r_cnt;
        logic            w_push;
        logic            w_pop;
        logic [EW-1:0]   w_head;

        assign w_full[i]        = r_cnt == CNTW'(DEPTH);
        assign w_push           = umi_in_valid && umi_in_ready && w_sel == SW'(i);
        assign w_pop            = umi_out_valid[i] && umi_out_ready[i];
        assign umi_out_valid[i] = r_cnt != '0;
        assign w_head           = r_mem[r_rptr];

        assign umi_out_cmd[i*CW +: CW]          = w_head[DW+2*AW +: CW];
        assign umi_out_dstaddr[i*AW +: AW]      = w_head[DW+AW +: AW];
        assign umi_out_srcaddr[i*AW +: AW]      = w_head[DW +: AW];
        assign umi_out_data[i*DW +: DW]         = w_head[0 +: DW];
        assign fifo_count[i*CNTW +: CNTW]       = r_cnt;

        always_ff @(posedge clk) begin
            if (w_push)
                r_mem[r_wptr] <= w_entry;
        end

        always_ff @(posedge clk) begin
            if (!nreset) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + PW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + PW'(1);
                r_cnt <= r_cnt + CNTW'(w_push) - CNTW'(w_pop);
            end
        end
    end
endmodule

// File: doc/umi_splitter_n.md
UMI_SPLITTER_N -- requirements
Module: umi_splitter_n

Interface
REQ-001 SHALL have parameter DW, default 256, meaning data width.
REQ-002 SHALL have parameter AW, default 64, meaning address width.
REQ-003 SHALL have parameter CW, default 32, meaning command width.
REQ-004 SHALL have parameter N, default 4, meaning output channel count; legal values are 2, 4 or 8.
REQ-005 SHALL have parameter DEPTH, default 4, meaning per-output FIFO entries; legal values are powers of two, at least 2.
REQ-006 SHALL have parameter SELLSB, default 40, meaning the LSB of the dstaddr route field; SELLSB+log2(N) <= AW.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port nreset, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have ports umi_in_valid/cmd/dstaddr/srcaddr/data/ready: input, input CW, input AW, input AW, input DW, output 1; the UMI input packet.
REQ-010 SHALL have ports umi_out_valid, output N: per-channel valid.
REQ-011 SHALL have ports umi_out_cmd/dstaddr/srcaddr/data, outputs N*CW, N*AW, N*AW, N*DW: channel i in slice [i*W +: W].
REQ-012 SHALL have port umi_out_ready, input N: per-channel ready.
REQ-013 SHALL have port fifo_count, output N*$clog2(DEPTH+1): per-channel occupancy, channel i in slice i.

Function
REQ-014 SHALL set destination channel sel = umi_in_dstaddr[SELLSB +: log2(N)], evaluated combinationally each cycle.
REQ-015 SHALL drive umi_in_ready = !full[sel]; ready SHALL NOT depend on the same-cycle pop of that FIFO (no full-bypass).
REQ-016 SHALL push {cmd,dstaddr,srcaddr,data} into FIFO[sel] when umi_in_valid && umi_in_ready; all other FIFOs are unchanged.
REQ-017 SHALL have each FIFO registered with one-cycle latency: a packet accepted at edge t is visible on umi_out_* of its channel after edge t, with valid high, never earlier.
REQ-018 SHALL drive umi_out_valid[i] = !empty[i], with the payload slices showing the FIFO[i] head; the payload SHALL hold stable while valid && !ready.
REQ-019 SHALL pop FIFO[i] when umi_out_valid[i] && umi_out_ready[i].
REQ-020 SHALL preserve per-channel order (strict FIFO); no ordering guarantee exists across channels.
REQ-021 SHALL support simultaneous push and pop on one FIFO in the same cycle when not full: count is unchanged and both operations succeed.
REQ-022 SHALL allow push and pop on an empty FIFO in the same cycle only as a push; valid is low that cycle, so no pop occurs.
REQ-023 SHALL make read/write pointers log2(DEPTH) bits wide, wrapping modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-024 SHALL block head-of-line when FIFO[sel] is full: ready stays low and the input packet is not dropped; other channels continue to drain.
REQ-025 SHALL ignore payload inputs while umi_in_valid is low; valid deasserting without a handshake is legal.
REQ-026 SHALL be fully synthesizable, with no combinational path from umi_out_ready to umi_in_ready.

Reset
REQ-027 SHALL, while nreset is low at a clk edge, clear all pointers and counts: umi_out_valid = 0, fifo_count = 0, umi_in_ready = 1.
REQ-028 SHALL discard all buffered packets on reset mid-operation; output payload values are don't-care while valid is low.
REQ-029 SHALL ignore handshakes in the cycle that nreset is sampled low.

Verification
REQ-030 SHALL cover basic routing: with N=4, SELLSB=40, send dstaddr 0x0000_0300_0000_0000 with data 0xA5 -> the packet appears only on channel 3 one cycle later with data 0xA5, and fifo_count[3] is 1 until popped.
REQ-031 SHALL cover full FIFO: hold out_ready[1]=0 and send 5 packets to channel 1 with DEPTH=4 -> 4 are accepted, umi_in_ready=0 on the 5th, and fifo_count[1]=4; release ready -> the 5th is accepted and all 5 exit in order.
REQ-032 SHALL cover no head-of-line side effects: with channel 1 full and stalled, packets to channel 2 are still accepted and delivered.
REQ-033 SHALL cover wrap-around: send 10 packets to channel 0 with out_ready toggling 1/0 -> data is received in order 0..9 and the count never exceeds 4.
REQ-034 SHALL cover simultaneous push/pop: channel 2 holds 2 entries, with push and pop in the same cycle -> count stays 2 and order is preserved.
REQ-035 SHALL cover reset mid-traffic: with 3 entries buffered, assert nreset low for 1 cycle -> all valid=0, all counts=0, in_ready=1, and no stale packet emerges afterwards.
